md6_pad_responder: RTL and testbench

Device-side responder for the Mega Drive 3/6-button pad protocol carried on the DB9 user-port lines. It watches the host's select (TH) line and drives the six data lines with the button states that a genuine pad would present in each select phase, including the 6-button ID and extended-button phases. It is the counterpart of the DB9MD reader and is used as a pad model in benches and for pass-through/loopback builds.

---
 rtl/md6_pad_responder_if.sv | 22 ++
 rtl/md6_pad_responder.sv | 121 ++++++++++++
 tb/tb_md6_pad_responder.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/md6_pad_responder_if.sv
// Pad-side signal bundle for the Mega Drive pad responder: host select in, pad data out.
// The master drives select and the button states; the slave is the pad model.
interface md6_pad_responder_if;
    logic        select;
    logic [11:0] buttons;
    logic [5:0]  pad_out;
    logic        active;

    modport master (
        output select,
        output buttons,
        input  pad_out,
        input  active
    );

    modport slave (
        input  select,
        input  buttons,
        output pad_out,
        output active
    );
endinterface

// File: rtl/md6_pad_responder.sv
// Mega Drive 3/6-button pad responder: tracks host select phases and drives the data
// lines a genuine pad would present, including the 6-button ID and extended phases.
module md6_pad_responder #(
    parameter bit          SIX_BTN     = 1'b1,
    parameter int unsigned TIMEOUT_CYC = 72000
) (
    input logic          clk,
    input logic          reset_n,
    md6_pad_responder_if.slave pad
);

    localparam logic [16:0] TmoLast = 17'(TIMEOUT_CYC - 1);

    localparam logic [2:0] CntIdle = 3'd0;
    localparam logic [2:0] CntId   = 3'd3;
    localparam logic [2:0] CntMax  = 3'd4;

    localparam int unsigned BtnR = 0;
    localparam int unsigned BtnL = 1;
    localparam int unsigned BtnD = 2;
    localparam int unsigned BtnU = 3;
    localparam int unsigned BtnA = 4;
    localparam int unsigned BtnB = 5;
    localparam int unsigned BtnC = 6;
    localparam int unsigned BtnX = 7;
    localparam int unsigned BtnY = 8;
    localparam int unsigned BtnZ = 9;
    localparam int unsigned BtnS = 10;
    localparam int unsigned BtnM = 11;

    logic        sync_q;
    logic        sel_s_q;
    logic        sel_d_q;
    logic        sel_fall;
    logic        sel_edge;
    logic [2:0]  cnt_q, cnt_d;
    logic [16:0] tmo_q, tmo_d;
    logic [5:0]  pad_out_q, pad_out_d;
    logic        active_q, active_d;

    logic [11:0] rel;
    logic [5:0]  pat_normal_high;
    logic [5:0]  pat_extended;
    logic [5:0]  pat_normal_low;
    logic [5:0]  pat_id;
    logic [5:0]  pat_id_end;

    assign sel_fall = sel_d_q & ~sel_s_q;
    assign sel_edge = sel_d_q ^ sel_s_q;

    // Phase counter and idle timeout; an edge always beats a coincident expiry.
    always_comb begin
        cnt_d = cnt_q;
        tmo_d = tmo_q;
        if (sel_edge) begin
            tmo_d = '0;
            if (sel_fall && (cnt_q < CntMax)) begin
                cnt_d = cnt_q + 3'd1;
            end
        end else if (tmo_q == TmoLast) begin
            cnt_d = CntIdle;
        end else begin
            tmo_d = tmo_q + 17'd1;
        end
    end

    // rel is 1 for a released button, matching the active-low data lines.
    assign rel = ~pad.buttons;

    assign pat_normal_high = {rel[BtnC], rel[BtnB], rel[BtnR], rel[BtnL], rel[BtnD], rel[BtnU]};
    assign pat_extended    = {rel[BtnC], rel[BtnB], rel[BtnM], rel[BtnX], rel[BtnY], rel[BtnZ]};
    assign pat_normal_low  = {rel[BtnS], rel[BtnA], 2'b00, rel[BtnD], rel[BtnU]};
    assign pat_id          = {rel[BtnS], rel[BtnA], 4'b0000};
    assign pat_id_end      = {rel[BtnS], rel[BtnA], 4'b1111};

    // Select on the next cnt so the phase change and its pattern land together.
    always_comb begin
        pad_out_d = pat_normal_high;
        if (sel_s_q) begin
            if (SIX_BTN && (cnt_d == CntId)) begin
                pad_out_d = pat_extended;
            end else begin
                pad_out_d = pat_normal_high;
            end
        end else begin
            if (!SIX_BTN || (cnt_d < CntId)) begin
                pad_out_d = pat_normal_low;
            end else if (cnt_d == CntId) begin
                pad_out_d = pat_id;
            end else begin
                pad_out_d = pat_id_end;
            end
        end
    end

    assign active_d = (cnt_d != CntIdle);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q    <= 1'b1;
            sel_s_q   <= 1'b1;
            sel_d_q   <= 1'b1;
            cnt_q     <= CntIdle;
            tmo_q     <= '0;
            pad_out_q <= 6'h3F;
            active_q  <= 1'b0;
        end else begin
            sync_q    <= pad.select;
            sel_s_q   <= sync_q;
            sel_d_q   <= sel_s_q;
            cnt_q     <= cnt_d;
            tmo_q     <= tmo_d;
            pad_out_q <= pad_out_d;
            active_q  <= active_d;
        end
    end

    assign pad.pad_out = pad_out_q;
    assign pad.active  = active_q;

endmodule

// File: tb/tb_md6_pad_responder.sv
// Bench for md6_pad_responder: 6-button and 3-button instances share stimulus and are
// compared every cycle against a phase-level model, plus hand-computed spot checks.
module tb_md6_pad_responder;

    localparam int unsigned T = 300;

    logic        clk     = 1'b0;
    logic        reset_n = 1'b0;
    logic        select  = 1'b1;
    logic [11:0] buttons = 12'h000;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    always #5 clk = ~clk;

    md6_pad_responder_if if6 ();
    md6_pad_responder_if if3 ();

    assign if6.select  = select;
    assign if6.buttons = buttons;
    assign if3.select  = select;
    assign if3.buttons = buttons;

    md6_pad_responder #(.SIX_BTN(1'b1), .TIMEOUT_CYC(T)) dut6 (
        .clk     (clk),
        .reset_n (reset_n),
        .pad     (if6)
    );

    md6_pad_responder #(.SIX_BTN(1'b0), .TIMEOUT_CYC(T)) dut3 (
        .clk     (clk),
        .reset_n (reset_n),
        .pad     (if3)
    );

    // Model: the pin is seen by the pad two clocks late; phases counted on seen falls.
    bit          m_pin_q1 = 1'b1;
    bit          m_seen   = 1'b1;
    bit          m_prev   = 1'b1;
    int unsigned m_cnt    = 0;
    int unsigned m_idle   = 0;
    logic [5:0]  exp6     = 6'h3F;
    logic [5:0]  exp3     = 6'h3F;
    logic        exp_act  = 1'b0;

    function automatic logic [5:0] pattern(bit six, bit sel, int unsigned cnt, logic [11:0] b);
        logic [11:0] r;
        r = ~b;
        if (sel) begin
            if (six && cnt == 3) return {r[6], r[5], r[11], r[7], r[8], r[9]};
            return {r[6], r[5], r[0], r[1], r[2], r[3]};
        end
        if (!six || cnt <= 2) return {r[10], r[4], 2'b00, r[2], r[3]};
        if (cnt == 3) return {r[10], r[4], 4'h0};
        return {r[10], r[4], 4'hF};
    endfunction

    initial begin
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) begin
                m_pin_q1 = 1'b1;
                m_seen   = 1'b1;
                m_prev   = 1'b1;
                m_cnt    = 0;
                m_idle   = 0;
                exp6     = 6'h3F;
                exp3     = 6'h3F;
                exp_act  = 1'b0;
            end else begin
                if (m_prev != m_seen) begin
                    m_idle = 0;
                    if (m_prev && !m_seen && m_cnt < 4) m_cnt = m_cnt + 1;
                end else if (m_idle == T - 1) begin
                    m_cnt = 0;
                end else begin
                    m_idle = m_idle + 1;
                end
                exp6     = pattern(1'b1, m_seen, m_cnt, buttons);
                exp3     = pattern(1'b0, m_seen, m_cnt, buttons);
                exp_act  = (m_cnt != 0);
                m_prev   = m_seen;
                m_seen   = m_pin_q1;
                m_pin_q1 = select;
            end
        end
    end

    task automatic check(string name, logic [5:0] got, logic [5:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, got, want);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            check("model_pad6", if6.pad_out, exp6);
            check("model_pad3", if3.pad_out, exp3);
            check("model_act6", {5'b0, if6.active}, {5'b0, exp_act});
            check("model_act3", {5'b0, if3.active}, {5'b0, exp_act});
        end
    end

    task automatic tick(int unsigned n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic phase(bit v, int unsigned len);
        select = v;
        tick(len);
    endtask

    initial begin
        int unsigned guard;

        // Reset state, during and after reset.
        tick(3);
        check("rst_pad6", if6.pad_out, 6'h3F);
        check("rst_act6", {5'b0, if6.active}, 6'h00);
        reset_n = 1'b1;
        tick(3);
        check("post_rst_pad3", if3.pad_out, 6'h3F);
        check("post_rst_act3", {5'b0, if3.active}, 6'h00);
        buttons = 12'h048;
        tick(1);
        check("uc_pad6", if6.pad_out, 6'h1E);
        check("uc_pad3", if3.pad_out, 6'h1E);

        // First low phase: three clocks from the pin to pad_out.
        buttons = 12'h0FF;
        tick(2);
        select = 1'b0;
        tick(2);
        check("sel_lat2_pad6", if6.pad_out, 6'h00);
        tick(1);
        check("sel_lat3_pad6", if6.pad_out, 6'b100000);
        check("sel_lat3_act6", {5'b0, if6.active}, 6'h01);
        phase(1'b1, T + 10);
        check("idle_act6", {5'b0, if6.active}, 6'h00);

        // Full 6-button read sequence.
        buttons = 12'hA00;
        phase(1'b0, 100);
        phase(1'b1, 100);
        phase(1'b0, 100);
        phase(1'b1, 100);
        phase(1'b0, 100);
        check("low3_id_pad6", if6.pad_out, 6'h30);
        check("low3_pad3", if3.pad_out, 6'h33);
        phase(1'b1, 100);
        check("high3_ext_pad6", if6.pad_out, 6'b110110);
        check("high3_pad3", if3.pad_out, 6'h3F);
        phase(1'b0, 100);
        check("low4_pad6", if6.pad_out, 6'h3F);
        check("low4_pad3", if3.pad_out, 6'h33);
        phase(1'b1, 100);
        check("high4_pad6", if6.pad_out, 6'h3F);
        tick(T + 5);

        // Timeout after two falls.
        phase(1'b0, 50);
        phase(1'b1, 50);
        phase(1'b0, 50);
        select = 1'b1;
        tick(T + 2);
        check("tmo_hold_act6", {5'b0, if6.active}, 6'h01);
        tick(1);
        check("tmo_clear_act6", {5'b0, if6.active}, 6'h00);
        select = 1'b0;
        tick(3);
        check("tmo_restart_pad6", if6.pad_out, 6'h33);
        check("tmo_restart_act6", {5'b0, if6.active}, 6'h01);

        // Edge landing exactly on the expiry cycle: the fall wins and counts.
        phase(1'b1, 50);
        phase(1'b0, 50);
        select = 1'b1;
        tick(5);
        guard = 0;
        while (m_idle != T - 3 && guard < 2 * T) begin
            tick(1);
            guard++;
        end
        n_checks++;
        if (guard < 2 * T) n_pass++;
        else $display("FAIL expiry_align: waited %0d cycles, limit %0d", guard, 2 * T);
        select = 1'b0;
        tick(3);
        check("expiry_edge_model_cnt", 6'(m_cnt), 6'd3);
        check("expiry_edge_pad6", if6.pad_out, 6'h30);
        check("expiry_edge_act6", {5'b0, if6.active}, 6'h01);
        phase(1'b1, T + 5);

        // Reset between the third fall and the third rise.
        phase(1'b0, 20);
        phase(1'b1, 20);
        phase(1'b0, 20);
        phase(1'b1, 20);
        phase(1'b0, 20);
        check("pre_rst_pad6", if6.pad_out, 6'h30);
        reset_n = 1'b0;
        #1;
        check("async_rst_pad6", if6.pad_out, 6'h3F);
        check("async_rst_act6", {5'b0, if6.active}, 6'h00);
        tick(2);
        reset_n = 1'b1;
        tick(3);
        check("after_rst_pad6", if6.pad_out, 6'h33);
        check("after_rst_act6", {5'b0, if6.active}, 6'h01);

        // Randomized phases, button churn, near-timeout holds and occasional resets.
        for (int p = 0; p < 250; p++) begin
            int unsigned kind;
            int unsigned len;
            kind = $urandom_range(0, 19);
            if (kind == 0) len = T - 4 + $urandom_range(0, 8);
            else if (kind < 3) len = 1;
            else len = $urandom_range(2, 40);
            if (kind == 19) begin
                reset_n = 1'b0;
                tick(1);
                reset_n = 1'b1;
            end
            select = ~select;
            for (int c = 0; c < int'(len); c++) begin
                if ($urandom_range(0, 3) == 0) buttons = 12'($urandom);
                tick(1);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
